// File: rtl/i2c_apb_pkg.sv
// ============================================================================
// Package  : i2c_apb_pkg
// Brief    : Register offsets, STATUS bit positions and decode helper for
//            the I2C APB slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2c_apb_pkg;

  localparam int ADDR_W_DEFAULT  = 7;
  localparam int FIFO_AW_DEFAULT = 4;

  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_ADDR   = 32'h04;
  localparam logic [31:0] OFF_IER    = 32'h08;
  localparam logic [31:0] OFF_DATA   = 32'h0C;
  localparam logic [31:0] OFF_STATUS = 32'h10;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_FULL   = 2;
  localparam int ST_RX_EMPTY  = 3;
  localparam int ST_TX_OVF    = 4;
  localparam int ST_RX_UNF    = 5;
  localparam int ST_CORE_BUSY = 6;

  typedef enum logic [2:0] {
    REG_CTRL, REG_ADDR, REG_IER, REG_DATA, REG_STATUS, REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [31:0] off);
    case (off)
      OFF_CTRL:   return REG_CTRL;
      OFF_ADDR:   return REG_ADDR;
      OFF_IER:    return REG_IER;
      OFF_DATA:   return REG_DATA;
      OFF_STATUS: return REG_STATUS;
      default:    return REG_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_sync_fifo.sv
// ============================================================================
// Module   : i2c_sync_fifo
// Brief    : Single-clock FIFO with extra-MSB pointers; push on full and pop
//            on empty are ignored. Storage is not reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_sync_fifo #(
  parameter int WIDTH   = 8,
  parameter int FIFO_AW = 4
) (
  input  logic             pclk,
  input  logic             prst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam logic [FIFO_AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  // Gated on the pre-edge flags, so a pop never makes room for a same-cycle push
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr[FIFO_AW-1:0]];

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge pclk) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/i2c_apb_slave.sv
// ============================================================================
// Module   : i2c_apb_slave
// Brief    : Zero-wait APB completer for the I2C core: CTRL/ADDR/IER/STATUS
//            registers plus TX/RX byte FIFOs behind DATA. Optional macro
//            APB_PSLVERR_EN enables the pslverr error response.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_apb_slave
  import i2c_apb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEFAULT,
  parameter int DATA_W  = 32,
  parameter int FIFO_AW = FIFO_AW_DEFAULT
) (
  input  logic              pclk,
  input  logic              prst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              tx_rd,
  output logic [7:0]        tx_data,
  output logic              tx_empty,
  input  logic              rx_wr,
  input  logic [7:0]        rx_data,
  output logic              rx_full,
  input  logic              core_busy,
  output logic              ctrl_en,
  output logic              start_pulse,
  output logic [6:0]        slv_addr,
  output logic              irq
);

  reg_sel_e    sel;
  logic        xfer, wr_xfer, rd_xfer;
  logic        tx_push, rx_pop, tx_full, rx_empty;
  logic [7:0]  rx_head, rd_byte;
  logic        tx_ovf, rx_unf, tx_ovf_set, rx_unf_set;
  logic [5:0]  ier;
  logic [6:0]  status;
  logic        unused_bits;

  assign unused_bits = ^{paddr[31:ADDR_W], pwdata[DATA_W-1:8]};

  assign sel     = decode_offset(32'(paddr[ADDR_W-1:0]));
  assign xfer    = psel & penable;
  assign wr_xfer = xfer & pwrite;
  assign rd_xfer = xfer & ~pwrite;
  assign pready  = 1'b1;

  assign tx_push    = wr_xfer & (sel == REG_DATA);
  assign rx_pop     = rd_xfer & (sel == REG_DATA);
  assign tx_ovf_set = tx_push & tx_full;
  assign rx_unf_set = rx_pop & rx_empty;

  assign status = {core_busy, rx_unf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};
  assign irq    = |(status[5:0] & ier);

  i2c_sync_fifo #(.WIDTH(8), .FIFO_AW(FIFO_AW)) u_tx_fifo (
    .pclk(pclk), .prst_n(prst_n), .push(tx_push), .pop(tx_rd),
    .wr_data(pwdata[7:0]), .rd_data(tx_data), .full(tx_full), .empty(tx_empty)
  );

  i2c_sync_fifo #(.WIDTH(8), .FIFO_AW(FIFO_AW)) u_rx_fifo (
    .pclk(pclk), .prst_n(prst_n), .push(rx_wr), .pop(rx_pop),
    .wr_data(rx_data), .rd_data(rx_head), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      ctrl_en     <= 1'b0;
      start_pulse <= 1'b0;
      slv_addr    <= '0;
      ier         <= '0;
      tx_ovf      <= 1'b0;
      rx_unf      <= 1'b0;
    end else begin
      start_pulse <= wr_xfer & (sel == REG_CTRL) & pwdata[1];
      if (wr_xfer && sel == REG_CTRL) ctrl_en  <= pwdata[0];
      if (wr_xfer && sel == REG_ADDR) slv_addr <= pwdata[6:0];
      if (wr_xfer && sel == REG_IER)  ier      <= pwdata[5:0];
      // A set event in the clearing cycle keeps the sticky bit high
      tx_ovf <= tx_ovf_set |
                (tx_ovf & ~(wr_xfer & (sel == REG_STATUS) & pwdata[ST_TX_OVF]));
      rx_unf <= rx_unf_set |
                (rx_unf & ~(wr_xfer & (sel == REG_STATUS) & pwdata[ST_RX_UNF]));
    end
  end

  always_comb begin
    rd_byte = 8'h00;
    case (sel)
      REG_CTRL:   rd_byte = {7'b0, ctrl_en};
      REG_ADDR:   rd_byte = {1'b0, slv_addr};
      REG_IER:    rd_byte = {2'b0, ier};
      REG_DATA:   rd_byte = rx_empty ? 8'h00 : rx_head;
      REG_STATUS: rd_byte = {1'b0, status};
      default:    rd_byte = 8'h00;
    endcase
  end

  assign prdata = (psel & ~pwrite & prst_n) ? {{(DATA_W-8){1'b0}}, rd_byte} : '0;

`ifdef APB_PSLVERR_EN
  assign pslverr = prst_n & xfer & ((sel == REG_NONE) |
                   (pwrite & (sel == REG_STATUS) & (|pwdata[3:0])) |
                   tx_ovf_set | rx_unf_set);
`else
  assign pslverr = 1'b0;
`endif

endmodule

`default_nettype wire
